// File: rtl/mdu_pkg.sv
// Shared constants, op encodings and FSM states for the multiply/divide unit.
package mdu_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module mdu_step
    import mdu_pkg::*;
(
    input  logic             div_mode,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic             acc_lsb,
    input  logic             acc_msb,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] nxt_hi,
    output logic             nxt_bit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             carry_n;
    logic             borrow;

    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lsb ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        shifted = {acc_hi, acc_msb};
        // A set bit 32 in the shifted remainder can never borrow against a 32-bit divisor.
        {carry_n, diff} = {1'b0, shifted[WIDTH-1:0]} - {1'b0, opnd};
        borrow  = carry_n & ~shifted[WIDTH];
        if (div_mode) begin
            nxt_hi  = borrow ? shifted[WIDTH-1:0] : diff;
            nxt_bit = ~borrow;
        end else begin
            nxt_hi  = sum[WIDTH:1];
            nxt_bit = sum[0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; 34 busy cycles per op.
// One priming cycle loads the shift register, then 32 steps, then a sign-fix cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic                 primed;
    logic                 div_q;
    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     step_hi;
    logic                 step_bit;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;
    logic                 signed_op;

    assign signed_op = op[0];
    assign busy      = (state != IDLE);

    mdu_step u_step (
        .div_mode (div_q),
        .acc_hi   (acc[2*WIDTH-1:WIDTH]),
        .acc_lsb  (acc[0]),
        .acc_msb  (acc[WIDTH-1]),
        .opnd     (div_q ? b_q : a_q),
        .nxt_hi   (step_hi),
        .nxt_bit  (step_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (primed && cnt == {CNT_W{1'b1}}) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sign flags are only captured for signed ops, so unsigned ops never get corrected.
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
        rem_fix  = sign_a ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        if (b_q == '0)
            quo_fix = {WIDTH{1'b1}};
        else
            quo_fix = (sign_a ^ sign_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            primed <= 1'b0;
            div_q  <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_q  <= op[1];
                        sign_a <= signed_op & a[WIDTH-1];
                        sign_b <= signed_op & b[WIDTH-1];
                        a_q    <= mag(a, signed_op & a[WIDTH-1]);
                        b_q    <= mag(b, signed_op & b[WIDTH-1]);
                        cnt    <= '0;
                        primed <= 1'b0;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    if (!primed) begin
                        acc    <= {{WIDTH{1'b0}}, (div_q ? a_q : b_q)};
                        primed <= 1'b1;
                    end else begin
                        // Divide shifts quotient bits in at the bottom; multiply shifts product bits down.
                        if (div_q) acc <= {step_hi, acc[WIDTH-2:0], step_bit};
                        else       acc <= {step_hi, step_bit, acc[WIDTH-1:1]};
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (div_q) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table, random ops against a behavioural model, corner sequences.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, exp_hi, exp_lo;
    } vec_t;

    vec_t        vecs[10];
    logic [63:0] sb[$];

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sp;
        logic signed [31:0] sx, sy, q, r;
        sx = x;
        sy = y;
        case (o)
            OP_MULTU: return {32'd0, x} * {32'd0, y};
            OP_MULT: begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                return sp;
            end
            OP_DIVU: return (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
            default: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                q = sx / sy;
                r = sx % sy;
                return {r, q};
            end
        endcase
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs to show operands were latched.
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done(input string name, input bit chk_lat);
        int cyc;
        logic [63:0] e;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check({name, " done"}, {31'd0, busy}, 32'd0);
        if (chk_lat) check({name, " busy_cycles"}, cyc, 32'd34);
        if (sb.size() == 0) begin
            check({name, " scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({name, " hi"}, hi, e[63:32]);
            check({name, " lo"}, lo, e[31:0]);
        end
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb, lo_prev;

        vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{OP_DIVU,  32'd9,        32'd4,        32'd1,        32'd2};
        vecs[6] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[7] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};
        vecs[8] = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[9] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0};

        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].exp_hi, vecs[i].exp_lo});
            wait_done($sformatf("vec%0d", i), 1'b1);
        end

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 0) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 20)) : $urandom);
            launch(ro, ra, rb, model(ro, ra, rb));
            wait_done($sformatf("rand%0d", i), 1'b0);
        end

        // MTHI alone, then MTHI+MTLO together.
        lo_prev = lo;
        @(negedge clk); mthi = 1'b1; wdata = 32'h12345678;
        @(negedge clk); mthi = 1'b0;
        check("mthi hi", hi, 32'h12345678);
        check("mthi lo_kept", lo, lo_prev);
        @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5A5A5;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
        check("mthi_mtlo hi", hi, 32'hA5A5A5A5);
        check("mthi_mtlo lo", lo, 32'hA5A5A5A5);

        // MTLO and a second start while busy are dropped; hi/lo hold until the result lands.
        launch(OP_MULTU, 32'd6, 32'd7, {32'd0, 32'd42});
        repeat (5) @(negedge clk);
        mtlo = 1'b1; wdata = 32'hDEADBEEF; start = 1'b1; op = OP_MULTU; a = 32'd1; b = 32'd1;
        @(negedge clk);
        mtlo = 1'b0; start = 1'b0;
        check("busy_ignore mid hi", hi, 32'hA5A5A5A5);
        check("busy_ignore mid lo", lo, 32'hA5A5A5A5);
        wait_done("busy_ignore", 1'b0);
        @(negedge clk);
        check("busy_ignore no_queue", {31'd0, busy}, 32'd0);

        // Asynchronous reset with the counter at 10 discards the running op.
        launch(OP_DIVU, 32'h0000FFFF, 32'd3, model(OP_DIVU, 32'h0000FFFF, 32'd3));
        repeat (11) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset busy", {31'd0, busy}, 32'd0);
        check("async_reset hi", hi, 32'd0);
        check("async_reset lo", lo, 32'd0);
        void'(sb.pop_back());
        @(negedge clk); reset = 1'b0;
        launch(OP_DIVU, 32'd9, 32'd4, {32'd1, 32'd2});
        wait_done("after_reset", 1'b1);

        // start and mthi together: start wins.
        @(negedge clk);
        op = OP_MULTU; a = 32'd6; b = 32'd7; start = 1'b1; mthi = 1'b1; wdata = 32'hFFFF0000;
        sb.push_back({32'd0, 32'd42});
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        wait_done("start_mthi", 1'b1);

        check("scoreboard drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
